// File: rtl/rx_cmd_pkg.sv
// Shared constants and state encoding for the UART command sequencer.
// Opcodes are full bytes; operand addresses are register-file slots for the ALU.
package rx_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FN,
    S_ALU_WAIT,
    S_TX_LO,
    S_TX_HI
  } state_t;

endpackage

// File: rtl/rx_cmd_ctrl.sv
// Command sequencer: parses RX byte frames into register-file and ALU operations
// and returns read data / ALU results to the transmitter one byte at a time.
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// WR_ADDR    | write frame, expecting address
// WR_DATA    | write frame, expecting data
// RD_ADDR    | read frame, expecting address
// RD_WAIT    | waiting for register-file read data
// ALU_A      | ALU frame, expecting operand A
// ALU_B      | ALU frame, expecting operand B
// ALU_FN     | ALU frame, expecting function byte
// ALU_WAIT   | waiting for ALU result
// TX_LO      | offering low result byte
// TX_HI      | offering high result byte
module rx_cmd_ctrl
  import rx_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_Valid,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  output logic                    CMD_ERR
);

  state_t                  state_q, state_d;
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic                    alu_en_q, alu_en_d;
  logic                    clk_en_q, clk_en_d;
  logic                    cmd_err_q, cmd_err_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   frm_addr_q, frm_addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              fun_q, fun_d;
  logic [DATA_WIDTH-1:0]   txd_q, txd_d;
  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    len2_q, len2_d;
  logic                    tx_acc;

  assign tx_acc    = ((state_q == S_TX_LO) || (state_q == S_TX_HI)) && !TX_BUSY;
  assign TX_D_VLD  = tx_acc;
  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign ALU_EN    = alu_en_q;
  assign CLK_EN    = clk_en_q;
  assign CMD_ERR   = cmd_err_q;
  assign Address   = addr_q;
  assign WrData    = wdata_q;
  assign ALU_FUN   = fun_q;
  assign TX_P_DATA = txd_q;

  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    cmd_err_d  = 1'b0;
    addr_d     = addr_q;
    frm_addr_d = frm_addr_q;
    wdata_d    = wdata_q;
    fun_d      = fun_q;
    txd_d      = txd_q;
    res_d      = res_q;
    len2_d     = len2_q;

    unique case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_d = S_WR_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = S_RD_ADDR;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = S_ALU_A;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = S_ALU_FN;
          else                                            cmd_err_d = 1'b1;
        end
      end
      // Frame address is kept apart from Address so the output holds until the strobe.
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          frm_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d    = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d = 1'b1;
          addr_d  = frm_addr_q;
          wdata_d = RX_P_DATA;
          state_d = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d = 1'b1;
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (RdData_Valid) begin
          res_d   = {{DATA_WIDTH{1'b0}}, RdData};
          len2_d  = 1'b0;
          txd_d   = RdData;
          state_d = S_TX_LO;
        end
      end
      S_ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(OPA_ADDR);
          wdata_d = RX_P_DATA;
          state_d = S_ALU_B;
        end
      end
      S_ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'(OPB_ADDR);
          wdata_d = RX_P_DATA;
          state_d = S_ALU_FN;
        end
      end
      S_ALU_FN: begin
        if (RX_D_VLD) begin
          alu_en_d = 1'b1;
          fun_d    = RX_P_DATA[3:0];
          state_d  = S_ALU_WAIT;
        end
      end
      S_ALU_WAIT: begin
        if (OUT_Valid) begin
          res_d   = ALU_OUT;
          len2_d  = 1'b1;
          txd_d   = ALU_OUT[DATA_WIDTH-1:0];
          state_d = S_TX_LO;
        end
      end
      S_TX_LO: begin
        if (tx_acc) begin
          txd_d   = len2_q ? res_q[2*DATA_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];
          state_d = len2_q ? S_TX_HI : S_IDLE;
        end
      end
      S_TX_HI: begin
        if (tx_acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bytes arriving while a response is pending are dropped.
    if (RX_D_VLD && ((state_q == S_RD_WAIT) || (state_q == S_ALU_WAIT) ||
                     (state_q == S_TX_LO)   || (state_q == S_TX_HI)))
      cmd_err_d = 1'b1;

    clk_en_d = (state_d == S_ALU_FN) || (state_d == S_ALU_WAIT);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
      addr_q     <= '0;
      frm_addr_q <= '0;
      wdata_q    <= '0;
      fun_q      <= '0;
      txd_q      <= '0;
      res_q      <= '0;
      len2_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      clk_en_q   <= clk_en_d;
      cmd_err_q  <= cmd_err_d;
      addr_q     <= addr_d;
      frm_addr_q <= frm_addr_d;
      wdata_q    <= wdata_d;
      fun_q      <= fun_d;
      txd_q      <= txd_d;
      res_q      <= res_d;
      len2_q     <= len2_d;
    end
  end

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Bench for rx_cmd_ctrl: directed frames pinned with literal expectations, then
// randomized traffic checked every cycle against a frame-level reference model.
module tb_rx_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, CMD_ERR;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, TX_P_DATA;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        TX_BUSY = 1'b0;

  rx_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .TX_BUSY(TX_BUSY), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  typedef enum int {M_PARSE, M_WRD, M_WALU, M_SEND} mph_t;
  mph_t       m_ph = M_PARSE;
  mph_t       ph_pre;
  logic [7:0] frm[$];
  logic [7:0] sendq[$];
  logic       m_acc = 1'b0;
  logic       m_init = 1'b0;
  logic       exp_wr = 0, exp_rd = 0, exp_alu = 0, exp_err = 0, exp_clk = 0;
  logic [3:0] exp_addr = 0, exp_fun = 0;
  logic [7:0] exp_wd = 0, exp_txd = 0;

  function automatic logic is_op(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hBB) || (b == 8'hCC) || (b == 8'hDD);
  endfunction

  task automatic m_write(input logic [3:0] a, input logic [7:0] d);
    exp_wr = 1; exp_addr = a; exp_wd = d;
  endtask

  task automatic m_frame_byte();
    int n;
    n = frm.size();
    case (frm[0])
      8'hAA: if (n == 3) begin m_write(frm[1][3:0], frm[2]); frm.delete(); end
      8'hBB: if (n == 2) begin
               exp_rd = 1; exp_addr = frm[1][3:0]; frm.delete(); m_ph = M_WRD;
             end
      8'hCC: begin
               if (n == 2) m_write(4'd0, frm[1]);
               if (n == 3) m_write(4'd1, frm[2]);
               if (n == 4) begin
                 exp_alu = 1; exp_fun = frm[3][3:0]; frm.delete(); m_ph = M_WALU;
               end
             end
      default: if (n == 2) begin   // 8'hDD
               exp_alu = 1; exp_fun = frm[1][3:0]; frm.delete(); m_ph = M_WALU;
             end
    endcase
  endtask

  always @(posedge CLK) begin
    m_acc = 0;
    exp_wr = 0; exp_rd = 0; exp_alu = 0; exp_err = 0;
    if (RST) begin
      m_init = 1;
      m_ph = M_PARSE;
      frm.delete(); sendq.delete();
      exp_addr = 0; exp_wd = 0; exp_fun = 0; exp_txd = 0;
    end else begin
      ph_pre = m_ph;
      if (ph_pre == M_WRD && RdData_Valid) begin
        sendq.push_back(RdData); m_ph = M_SEND;
      end else if (ph_pre == M_WALU && OUT_Valid) begin
        sendq.push_back(ALU_OUT[7:0]); sendq.push_back(ALU_OUT[15:8]); m_ph = M_SEND;
      end else if (ph_pre == M_SEND && !TX_BUSY) begin
        void'(sendq.pop_front()); m_acc = 1;
        if (sendq.size() == 0) m_ph = M_PARSE;
      end
      if (RX_D_VLD) begin
        if (ph_pre != M_PARSE) exp_err = 1;
        else if (frm.size() == 0 && !is_op(RX_P_DATA)) exp_err = 1;
        else begin frm.push_back(RX_P_DATA); m_frame_byte(); end
      end
      if (sendq.size() != 0) exp_txd = sendq[0];
    end
    exp_clk = (m_ph == M_WALU) ||
              (m_ph == M_PARSE && frm.size() != 0 &&
               ((frm[0] == 8'hCC && frm.size() == 3) || (frm[0] == 8'hDD && frm.size() == 1)));
  end

  // ---------------- per-cycle compare and event logs ----------------
  logic [11:0] wr_log[$];
  logic [3:0]  rd_log[$];
  logic [3:0]  alu_log[$];
  logic [7:0]  tx_log[$];
  int err_cnt = 0, clk_cnt = 0, cyc = 0, rd_cyc = 0, tx_cyc = 0;

  always @(negedge CLK) begin
    cyc++;
    if (m_init && !RST) begin
      chk("WrEn", WrEn, exp_wr);
      chk("RdEn", RdEn, exp_rd);
      chk("ALU_EN", ALU_EN, exp_alu);
      chk("CLK_EN", CLK_EN, exp_clk);
      chk("CMD_ERR", CMD_ERR, exp_err);
      chk("Address", Address, exp_addr);
      chk("WrData", WrData, exp_wd);
      chk("ALU_FUN", ALU_FUN, exp_fun);
      chk("TX_P_DATA", TX_P_DATA, exp_txd);
      chk("TX_D_VLD", TX_D_VLD, (sendq.size() != 0) && !TX_BUSY);
    end
    if (WrEn) wr_log.push_back({Address, WrData});
    if (RdEn) begin rd_log.push_back(Address); rd_cyc = cyc; end
    if (ALU_EN) alu_log.push_back(ALU_FUN);
    if (TX_D_VLD) begin tx_log.push_back(TX_P_DATA); tx_cyc = cyc; end
    if (CMD_ERR) err_cnt++;
    if (CLK_EN) clk_cnt++;
  end

  // ---------------- datapath / transmitter responders ----------------
  logic        rand_mode = 0;
  int          dir_dly = 1;
  logic [7:0]  dir_rd = 0;
  logic [15:0] dir_alu = 0;
  int          rd_t = 0, al_t = 0, b_hold = 0;

  always begin
    @(posedge CLK); #1;
    RdData_Valid = 0;
    OUT_Valid = 0;
    if (m_ph == M_WRD) begin
      if (rd_t == 0) begin
        RdData_Valid = 1; RdData = rand_mode ? 8'($urandom) : dir_rd;
      end else rd_t--;
    end else begin
      rd_t = rand_mode ? int'($urandom_range(0, 3)) : dir_dly;
      if (rand_mode && ($urandom % 16 == 0)) begin RdData_Valid = 1; RdData = 8'($urandom); end
    end
    if (m_ph == M_WALU) begin
      if (al_t == 0) begin
        OUT_Valid = 1; ALU_OUT = rand_mode ? 16'($urandom) : dir_alu;
      end else al_t--;
    end else begin
      al_t = rand_mode ? int'($urandom_range(0, 3)) : dir_dly;
      if (rand_mode && ($urandom % 16 == 0)) begin OUT_Valid = 1; ALU_OUT = 16'($urandom); end
    end
    if (m_acc) begin
      TX_BUSY = 1; b_hold = rand_mode ? int'($urandom_range(0, 2)) : 2;
    end else if (b_hold > 0) begin
      b_hold--; TX_BUSY = 1;
    end else TX_BUSY = rand_mode ? ($urandom % 4 == 0) : 1'b0;
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_D_VLD = 1; RX_P_DATA = b;
    @(posedge CLK); #1;
    RX_D_VLD = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clr_logs();
    wr_log.delete(); rd_log.delete(); alu_log.delete(); tx_log.delete(); clk_cnt = 0;
  endtask

  int e0;
  logic [7:0] pick[5];

  initial begin
    RST = 1;
    idle(3);
    @(posedge CLK); #1; RST = 0;
    idle(2);

    // write frame
    clr_logs();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    idle(4);
    chk("wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) chk("wr_addr_data", wr_log[0], 12'h53C);
    chk("wr_no_tx", tx_log.size(), 0);

    // read frame, data one cycle after RdEn
    clr_logs(); dir_dly = 1; dir_rd = 8'h3C;
    send_byte(8'hBB); send_byte(8'h15);
    idle(8);
    chk("rd_count", rd_log.size(), 1);
    if (rd_log.size() > 0) chk("rd_addr", rd_log[0], 4'h5);
    chk("rd_tx_count", tx_log.size(), 1);
    if (tx_log.size() > 0) chk("rd_tx_byte", tx_log[0], 8'h3C);
    chk("rd_latency", tx_cyc - rd_cyc, 2);

    // ALU frame with operands
    clr_logs(); dir_dly = 2; dir_alu = 16'h0046;
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'hF0);
    idle(14);
    chk("alu_wr_count", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("alu_opa", wr_log[0], 12'h012);
      chk("alu_opb", wr_log[1], 12'h134);
    end
    chk("alu_en_count", alu_log.size(), 1);
    if (alu_log.size() > 0) chk("alu_fun0", alu_log[0], 4'h0);
    chk("alu_clk_en_seen", clk_cnt != 0, 1);
    chk("alu_tx_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("alu_tx_lo", tx_log[0], 8'h46);
      chk("alu_tx_hi", tx_log[1], 8'h00);
    end

    // ALU frame without operands
    clr_logs(); dir_alu = 16'hABCD;
    send_byte(8'hDD); send_byte(8'h02);
    idle(14);
    chk("nop_wr_count", wr_log.size(), 0);
    if (alu_log.size() > 0) chk("nop_fun", alu_log[0], 4'h2);
    chk("nop_tx_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("nop_tx_lo", tx_log[0], 8'hCD);
      chk("nop_tx_hi", tx_log[1], 8'hAB);
    end

    // unknown opcode and RX byte while the ALU result is pending
    clr_logs(); e0 = err_cnt; dir_dly = 4; dir_alu = 16'h1234;
    send_byte(8'h55); send_byte(8'hDD); send_byte(8'h05); send_byte(8'h77);
    idle(16);
    chk("err_pulses", err_cnt - e0, 2);
    chk("err_tx_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("err_tx_lo", tx_log[0], 8'h34);
      chk("err_tx_hi", tx_log[1], 8'h12);
    end

    // reset mid-frame
    clr_logs(); e0 = err_cnt;
    send_byte(8'hAA); send_byte(8'h05);
    @(posedge CLK); #1; RST = 1;
    @(posedge CLK); #1; RST = 0;
    send_byte(8'h3C);
    idle(4);
    chk("rst_no_wr", wr_log.size(), 0);
    chk("rst_err", err_cnt - e0, 1);

    // randomized traffic
    rand_mode = 1;
    pick[0] = 8'hAA; pick[1] = 8'hBB; pick[2] = 8'hCC; pick[3] = 8'hDD; pick[4] = 8'h00;
    repeat (4000) begin
      @(posedge CLK); #1;
      RST = ($urandom % 400 == 0);
      RX_D_VLD = ($urandom % 3 == 0);
      if (m_ph == M_PARSE && frm.size() == 0) begin
        pick[4] = 8'($urandom);
        RX_P_DATA = pick[$urandom % 5];
      end else RX_P_DATA = 8'($urandom);
    end
    @(posedge CLK); #1;
    RST = 0; RX_D_VLD = 0; rand_mode = 0;
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
